window3x3_gen: RTL and testbench
================================

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 The block SHALL have the parameter PIX_W, default 8, giving pixel width in bits.
REQ-002 The block SHALL have the parameter IMG_W, default 64, giving image width in pixels (minimum 3).
REQ-003 The block SHALL have the parameter IMG_H, default 64, giving image height in rows (minimum 3).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rstn, input, 1 bit: the reset, synchronous and active-low.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: the input pixel is valid.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-008 The block SHALL have the port in_pix, input, PIX_W bits: the unsigned pixel, raster order.
REQ-009 The block SHALL have the port in_sof, input, 1 bit: start of frame, qualified by in_valid&&in_ready.
REQ-010 The block SHALL have the port win_valid, output, 1 bit: the window outputs hold a valid 3x3 window.
REQ-011 The block SHALL have the port win_ready, input, 1 bit: the downstream consumer (MAC stage) takes the window.
REQ-012 The block SHALL have the ports px0..px8, output, PIX_W bits each: the window, row-major; px0 = (r-2,c-2), px8 = (r,c).
REQ-013 The block SHALL have the port win_last, output, 1 bit: the last window of the frame, qualified by win_valid.

Function
REQ-014 A pixel SHALL be accepted when in_valid && in_ready; in_ready = !win_valid || win_ready (one-entry output register, full throughput).
REQ-015 On acceptance, the col and row counters SHALL advance: col wraps IMG_W-1 -> 0 with row++, and row wraps IMG_H-1 -> 0 (next frame).
REQ-016 An accepted pixel with in_sof=1 SHALL be treated as (row 0, col 0) regardless of counter state; the partial frame is dropped.
REQ-017 Two line buffers, depth IMG_W, SHALL be updated on acceptance: lb1[col] <= lb0[col] and lb0[col] <= in_pix.
REQ-018 A 3x3 shift array SHALL shift left one column per acceptance; the new right column = {lb1[col], lb0[col], in_pix} (top..bottom).
REQ-019 A window SHALL be emitted only for accepted pixels with row>=2 and col>=2 (valid convolution, no padding), giving (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 Latency SHALL be exactly 1 cycle: win_valid and px0..px8 are registered on the edge that accepts the completing pixel.
REQ-021 While win_valid && !win_ready, px0..px8, win_last and win_valid SHALL hold stable and in_ready SHALL be 0.
REQ-022 When win_ready=1 and an accepted pixel completes a new window in the same cycle, the outputs SHALL load the new window with no bubble.
REQ-023 win_valid SHALL clear on the handshake when no new window is loaded in that cycle.
REQ-024 win_last SHALL be 1 only with the window for (IMG_H-1, IMG_W-1).
REQ-025 Windows SHALL never mix columns across a row boundary; this follows from REQ-019, since the shift array refills on col 0 and col 1.

Reset
REQ-026 When rstn=0 at a clock edge: win_valid=0, win_last=0, px0..px8=0, in_ready=0 during reset, row=col=0, shift array=0.
REQ-027 Line-buffer contents SHALL NOT require reset; stale data is never emitted, per REQ-019.
REQ-028 A reset mid-frame SHALL discard the frame; the first pixel after reset is (0,0).

Structure
REQ-029 The package conv_pkg SHALL hold the PIX_W default, the pix_t typedef, and the window struct/array type shared with the MAC stage.
REQ-030 The block SHALL have one sub-module, line_buf: a single-clock RAM of depth IMG_W with read-before-write at the same address, instantiated twice.
REQ-031 The col and row counters SHALL be $clog2(IMG_W) and $clog2(IMG_H) bits wide.

Verification (IMG_W=5, IMG_H=4, raster ramp pix = 5r+c, win_ready=1 unless stated)
REQ-032 The bench SHALL cover first window: pixels 0..12 -> single win_valid one cycle after pixel 12, px0..8 = 0,1,2,5,6,7,10,11,12, and no window for pixels 0..11.
REQ-033 The bench SHALL cover row wrap: pixels 15,16 -> no window; pixel 17 -> 5,6,7,10,11,12,15,16,17.
REQ-034 The bench SHALL cover frame end: pixel 19 -> 7,8,9,12,13,14,17,18,19 with win_last=1, total window count 6, and the next frame restarting at (0,0).
REQ-035 The bench SHALL cover backpressure: win_ready=0 for 3 cycles on the first window -> in_ready=0, outputs stable; then win_ready=1 -> sequence identical to the unstalled run.
REQ-036 The bench SHALL cover in_sof at pixel 8 mid-frame -> the pixel is taken as (0,0), and the next window appears after 12 more pixels, at 13 pixels counting the in_sof pixel.
REQ-037 The bench SHALL cover reset: rstn=0 for 1 cycle after pixel 14 -> win_valid=0, px=0; the stream then restarts from pixel 0 and reproduces REQ-032.

Source files
------------

// File: rtl/conv_pkg.sv
// Types shared between the 3x3 window generator and the downstream MAC stage.
// A window is nine pixels in row-major order: tap 0 is top-left, tap 8 is bottom-right.
package conv_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_TAPS  = 9;
  localparam int WIN_DIM   = 3;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  // Flat packed form, index = 3*row + col inside the window
  typedef pix_t [WIN_TAPS-1:0] win_t;

  typedef struct packed {
    pix_t [WIN_DIM-1:0] top;
    pix_t [WIN_DIM-1:0] mid;
    pix_t [WIN_DIM-1:0] bot;
  } win_s;

endpackage

// File: rtl/window3x3_gen_line_buf.sv
// One image row of pixel storage with asynchronous read and synchronous write.
// A write at an address returns the old contents on the same cycle (read-before-write).
module line_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // No reset: rows are always rewritten before they can reach a window
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Streams raster pixels in and emits every fully populated 3x3 neighbourhood
// (no edge padding) through a one-entry registered output with full throughput.
module window3x3_gen
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [PIX_W-1:0] px0,
  output logic [PIX_W-1:0] px1,
  output logic [PIX_W-1:0] px2,
  output logic [PIX_W-1:0] px3,
  output logic [PIX_W-1:0] px4,
  output logic [PIX_W-1:0] px5,
  output logic [PIX_W-1:0] px6,
  output logic [PIX_W-1:0] px7,
  output logic [PIX_W-1:0] px8,
  output logic             win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN = CW'(WIN_DIM - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(WIN_DIM - 1);

  logic [CW-1:0] col, ecol;
  logic [RW-1:0] row, erow;
  logic          accept, emit, at_last;

  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] sh     [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0] sh_nxt [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0] win_q  [WIN_TAPS];

  assign in_ready = rstn && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is placed at the origin whatever the counters say
  assign ecol    = in_sof ? '0 : col;
  assign erow    = in_sof ? '0 : row;
  assign emit    = accept && (erow >= ROW_MIN) && (ecol >= COL_MIN);
  assign at_last = (erow == ROW_MAX) && (ecol == COL_MAX);

  // lb0 holds the previous row, lb1 the row before it; lb1 is fed from lb0's old word
  line_buf #(.W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (ecol),
    .wdata (in_pix),
    .rdata (lb0_rd)
  );

  line_buf #(.W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (ecol),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM - 1; c++) begin
        sh_nxt[r][c] = sh[r][c+1];
      end
    end
    sh_nxt[0][WIN_DIM-1] = lb1_rd;
    sh_nxt[1][WIN_DIM-1] = lb0_rd;
    sh_nxt[2][WIN_DIM-1] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          sh[r][c] <= '0;
        end
      end
      for (int k = 0; k < WIN_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        sh <= sh_nxt;
        if (ecol == COL_MAX) begin
          col <= '0;
          row <= (erow == ROW_MAX) ? '0 : erow + RW'(1);
        end else begin
          col <= ecol + CW'(1);
          row <= erow;
        end
      end
      // A new window overrides the handshake so back-to-back windows have no bubble
      if (emit) begin
        win_valid <= 1'b1;
        win_last  <= at_last;
        for (int r = 0; r < WIN_DIM; r++) begin
          for (int c = 0; c < WIN_DIM; c++) begin
            win_q[WIN_DIM*r+c] <= sh_nxt[r][c];
          end
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

  assign px0 = win_q[0];
  assign px1 = win_q[1];
  assign px2 = win_q[2];
  assign px3 = win_q[3];
  assign px4 = win_q[4];
  assign px5 = win_q[5];
  assign px6 = win_q[6];
  assign px7 = win_q[7];
  assign px8 = win_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 5x4 image: directed ramp frames, stall, mid-frame sof,
// reset, then random traffic, all compared against an image-array reference model.
module tb_window3x3_gen;

  localparam int PW = 8;
  localparam int IW = 5;
  localparam int IH = 4;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_sof    = 1'b0;
  logic          win_ready = 1'b1;
  logic [PW-1:0] in_pix    = '0;
  logic          in_ready, win_valid, win_last;
  logic [PW-1:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;
  logic [PW-1:0] pxa [9];

  window3x3_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .px0       (px0),
    .px1       (px1),
    .px2       (px2),
    .px3       (px3),
    .px4       (px4),
    .px5       (px5),
    .px6       (px6),
    .px7       (px7),
    .px8       (px8),
    .win_last  (win_last)
  );

  assign pxa[0] = px0;
  assign pxa[1] = px1;
  assign pxa[2] = px2;
  assign pxa[3] = px3;
  assign pxa[4] = px4;
  assign pxa[5] = px5;
  assign pxa[6] = px6;
  assign pxa[7] = px7;
  assign pxa[8] = px8;

  always #5 clk = ~clk;

  // Reference: the current frame as a 2D image plus the expected output register
  int   img [IH][IW];
  int   mrow = 0;
  int   mcol = 0;
  logic exp_valid = 1'b0;
  logic exp_last  = 1'b0;
  int   exp_px [9];
  int   nwin  = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic acc;

  int winA [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int winB [9] = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
  int winC [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("win_valid", win_valid, exp_valid);
    check("win_last", win_last, exp_last);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("px%0d", k), pxa[k], exp_px[k]);
    end
  endtask

  task automatic check_const(input string tag, input int e [9]);
    check({tag, "_valid"}, win_valid, 1);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_px%0d", tag, k), pxa[k], e[k]);
    end
  endtask

  task automatic do_reset(input int n);
    rstn      = 1'b0;
    in_valid  = 1'b1;
    in_pix    = 8'hA5;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    for (int k = 0; k < 9; k++) exp_px[k] = 0;
    mrow = 0;
    mcol = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("in_ready_in_reset", in_ready, 0);
      check_outputs();
    end
    rstn     = 1'b1;
    in_valid = 1'b0;
  endtask

  // One clock: drive at the falling edge, predict, check after the next falling edge
  task automatic cycle(input logic v, input logic [PW-1:0] p, input logic s,
                       input logic wr, output logic accepted);
    logic eready;
    in_valid  = v;
    in_pix    = p;
    in_sof    = s;
    win_ready = wr;
    #1;
    eready = !exp_valid || wr;
    check("in_ready", in_ready, eready);
    if (win_valid === 1'b1 && wr) nwin++;
    accepted = v && eready;
    if (accepted) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = p;
      if (mrow >= 2 && mcol >= 2) begin
        exp_valid = 1'b1;
        exp_last  = (mrow == IH - 1) && (mcol == IW - 1);
        for (int k = 0; k < 9; k++) exp_px[k] = img[mrow - 2 + k / 3][mcol - 2 + k % 3];
      end else if (wr) begin
        exp_valid = 1'b0;
        exp_last  = 1'b0;
      end
      mcol++;
      if (mcol == IW) begin
        mcol = 0;
        mrow = (mrow == IH - 1) ? 0 : mrow + 1;
      end
    end else if (wr) begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [PW-1:0] p, input logic s, input logic wr);
    logic a;
    a = 1'b0;
    for (int t = 0; t < 20 && !a; t++) cycle(1'b1, p, s, wr, a);
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic ramp(input int first, input int last, input logic sof_first);
    for (int i = first; i <= last; i++) send(PW'(i), sof_first && (i == first), 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset(2);

    // First frame: first window, row wrap, frame end
    nwin = 0;
    ramp(0, 11, 1'b1);
    check("no_early_win", win_valid, 0);
    ramp(12, 12, 1'b0);
    check_const("first_win", winA);
    check("first_win_last", win_last, 0);
    ramp(13, 16, 1'b0);
    check("row_wrap_gap", win_valid, 0);
    ramp(17, 17, 1'b0);
    check_const("row_wrap_win", winB);
    ramp(18, 19, 1'b0);
    check_const("frame_end_win", winC);
    check("frame_end_last", win_last, 1);
    idle();
    check("frame_win_count", nwin, 6);

    // Second frame without sof, stalled on its first window
    nwin = 0;
    ramp(0, 12, 1'b0);
    check_const("restart_win", winA);
    repeat (3) begin
      cycle(1'b1, 8'd13, 1'b0, 1'b0, acc);
      check("stall_in_ready", in_ready, 0);
      check_const("stall_hold", winA);
      check("stall_last", win_last, 0);
    end
    ramp(13, 17, 1'b0);
    check_const("post_stall_b", winB);
    ramp(18, 19, 1'b0);
    check_const("post_stall_c", winC);
    check("post_stall_last", win_last, 1);
    idle();
    check("stall_win_count", nwin, 6);

    // Mid-frame sof at pixel 8
    nwin = 0;
    for (int i = 0; i < 8; i++) send(PW'($urandom_range(0, 255)), 1'b0, 1'b1);
    send(PW'($urandom_range(0, 255)), 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) send(PW'($urandom_range(0, 255)), 1'b0, 1'b1);
    check("sof_no_win_yet", win_valid, 0);
    check("sof_no_hs_yet", nwin, 0);
    send(PW'($urandom_range(0, 255)), 1'b0, 1'b1);
    check("sof_win_at_13", win_valid, 1);
    for (int i = 0; i < 7; i++) send(PW'($urandom_range(0, 255)), 1'b0, 1'b1);
    idle();
    check("sof_win_count", nwin, 6);

    // Reset after pixel 14, then a clean restart
    ramp(0, 14, 1'b0);
    do_reset(1);
    ramp(0, 12, 1'b0);
    check_const("post_reset_win", winA);
    ramp(13, 19, 1'b0);
    idle();

    // Random traffic with gaps, backpressure and occasional sof
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, PW'($urandom_range(0, 255)),
            $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, acc);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
